// File: rtl/regfile_sb_param.sv
// regfile_sb_param
// Parametrised general-purpose register file for the pipelined core, with a
// per-register pending-write scoreboard, a sequential clear engine and a
// debug read port. Reads and scoreboard sets come from ID, writes from WB.
//
// Ports:
//   i_clk        clock, all state changes on the rising edge
//   i_rst        synchronous active-low reset
//   i_we         write enable from WB
//   i_wt_addr    write address
//   i_wt_data    write data
//   i_rs1_addr   read port 1 address
//   i_rs2_addr   read port 2 address
//   o_rs1_data   read port 1 data (combinational, optional bypass)
//   o_rs2_data   read port 2 data (combinational, optional bypass)
//   o_rs1_pend   register at i_rs1_addr has a write outstanding
//   o_rs2_pend   register at i_rs2_addr has a write outstanding
//   i_sb_set     ID issued an instruction that will write i_sb_addr
//   i_sb_addr    destination register being issued
//   i_clr_req    start a sequential clear of every entry
//   o_busy       clear engine active
//   i_dbg_addr   debug read address
//   o_dbg_data   debug read data (raw stored value, no bypass)

module regfile_sb_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_wt_addr,
  input  logic [DATA_W-1:0] i_wt_data,
  input  logic [ADDR_W-1:0] i_rs1_addr,
  input  logic [ADDR_W-1:0] i_rs2_addr,
  output logic [DATA_W-1:0] o_rs1_data,
  output logic [DATA_W-1:0] o_rs2_data,
  output logic              o_rs1_pend,
  output logic              o_rs2_pend,
  input  logic              i_sb_set,
  input  logic [ADDR_W-1:0] i_sb_addr,
  input  logic              i_clr_req,
  output logic              o_busy,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  output logic [DATA_W-1:0] o_dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DEPTH-1:0]    r_sb;

  logic w_idle;
  logic w_wr_ok;
  logic w_set_ok;
  logic w_zero1;
  logic w_zero2;
  logic w_zero_dbg;
  logic w_hit1;
  logic w_hit2;
  logic w_byp1;
  logic w_byp2;

  // Writes and scoreboard sets only take effect while the clear engine is
  // idle; entry 0 is hard-wired when ZERO_REG is enabled.
  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_ok  = w_idle && i_we &&
                    !((ZERO_REG != 0) && (i_wt_addr == '0));
  assign w_set_ok = w_idle && i_sb_set &&
                    !((ZERO_REG != 0) && (i_sb_addr == '0));

  assign w_zero1    = (ZERO_REG != 0) && (i_rs1_addr == '0);
  assign w_zero2    = (ZERO_REG != 0) && (i_rs2_addr == '0);
  assign w_zero_dbg = (ZERO_REG != 0) && (i_dbg_addr == '0);

  // A write in flight this cycle to the read address: it both hides the
  // pending bit (the producer is retiring now) and, with BYPASS, forwards data.
  assign w_hit1 = w_idle && i_we && (i_wt_addr == i_rs1_addr);
  assign w_hit2 = w_idle && i_we && (i_wt_addr == i_rs2_addr);
  assign w_byp1 = (BYPASS != 0) && w_wr_ok && (i_wt_addr == i_rs1_addr);
  assign w_byp2 = (BYPASS != 0) && w_wr_ok && (i_wt_addr == i_rs2_addr);

  assign o_rs1_data = w_zero1 ? '0 : (w_byp1 ? i_wt_data : r_mem[i_rs1_addr]);
  assign o_rs2_data = w_zero2 ? '0 : (w_byp2 ? i_wt_data : r_mem[i_rs2_addr]);
  assign o_rs1_pend = !w_zero1 && r_sb[i_rs1_addr] && !w_hit1;
  assign o_rs2_pend = !w_zero2 && r_sb[i_rs2_addr] && !w_hit2;
  assign o_dbg_data = w_zero_dbg ? '0 : r_mem[i_dbg_addr];
  assign o_busy     = (r_state == S_CLEAR);

  // Storage, scoreboard and clear engine. In IDLE the scoreboard set is
  // applied after the write's clear so that a newly issued producer wins over
  // one retiring in the same cycle. In CLEAR one entry is zeroed per cycle and
  // the engine stops on the all-ones count rather than relying on wrap.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sb    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_wr_ok) begin
            r_mem[i_wt_addr] <= i_wt_data;
            r_sb[i_wt_addr]  <= 1'b0;
          end
          if (w_set_ok) begin
            r_sb[i_sb_addr] <= 1'b1;
          end
          if (i_clr_req) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
          end
        end
        S_CLEAR: begin
          r_mem[r_cnt] <= '0;
          r_sb[r_cnt]  <= 1'b0;
          r_cnt        <= r_cnt + 1'b1;
          if (r_cnt == {ADDR_W{1'b1}}) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sb_param.sv
// tb_regfile_sb_param
// Self-checking bench for regfile_sb_param: a directed vector table, a few
// hand-written clear/reset sequences and a randomized phase, all compared
// against an array-based reference model. A second instance with BYPASS=0
// shares the inputs so that the non-forwarding read path is also covered.

module tb_regfile_sb_param;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wtAddr;
  logic [31:0] wtData;
  logic [4:0]  rs1Addr;
  logic [4:0]  rs2Addr;
  logic [31:0] rs1Data;
  logic [31:0] rs2Data;
  logic        rs1Pend;
  logic        rs2Pend;
  logic        sbSet;
  logic [4:0]  sbAddr;
  logic        clrReq;
  logic        busy;
  logic [4:0]  dbgAddr;
  logic [31:0] dbgData;

  logic [31:0] nbRs1Data;
  logic [31:0] nbRs2Data;
  logic        nbRs1Pend;
  logic        nbRs2Pend;
  logic        nbBusy;
  logic [31:0] nbDbgData;

  int checks;
  int failures;

  // Reference model state: plain arrays plus a clear progress index.
  logic [31:0] mMem [32];
  bit          mSb  [32];
  bit          mClearing;
  int          mIdx;

  regfile_sb_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_wt_addr(wtAddr), .i_wt_data(wtData),
    .i_rs1_addr(rs1Addr), .i_rs2_addr(rs2Addr),
    .o_rs1_data(rs1Data), .o_rs2_data(rs2Data),
    .o_rs1_pend(rs1Pend), .o_rs2_pend(rs2Pend),
    .i_sb_set(sbSet), .i_sb_addr(sbAddr), .i_clr_req(clrReq), .o_busy(busy),
    .i_dbg_addr(dbgAddr), .o_dbg_data(dbgData)
  );

  regfile_sb_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dutNb (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_wt_addr(wtAddr), .i_wt_data(wtData),
    .i_rs1_addr(rs1Addr), .i_rs2_addr(rs2Addr),
    .o_rs1_data(nbRs1Data), .o_rs2_data(nbRs2Data),
    .o_rs1_pend(nbRs1Pend), .o_rs2_pend(nbRs2Pend),
    .i_sb_set(sbSet), .i_sb_addr(sbAddr), .i_clr_req(clrReq), .o_busy(nbBusy),
    .i_dbg_addr(dbgAddr), .o_dbg_data(nbDbgData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Global time limit so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL timeout actual=running required=finished");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] modelStored(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : mMem[a];
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (!mClearing && we && wtAddr == a) return wtData;
    return mMem[a];
  endfunction

  function automatic logic modelPend(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (!mClearing && we && wtAddr == a) return 1'b0;
    return mSb[a];
  endfunction

  // Advances the model by one rising edge using the inputs held at that edge.
  task automatic modelUpdate();
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        mMem[i] = 32'd0;
        mSb[i]  = 1'b0;
      end
      mClearing = 1'b0;
      mIdx      = 0;
    end else if (mClearing) begin
      mMem[mIdx] = 32'd0;
      mSb[mIdx]  = 1'b0;
      mIdx++;
      if (mIdx == 32) mClearing = 1'b0;
    end else begin
      if (we && wtAddr != 5'd0) begin
        mMem[wtAddr] = wtData;
        mSb[wtAddr]  = 1'b0;
      end
      if (sbSet && sbAddr != 5'd0) mSb[sbAddr] = 1'b1;
      if (clrReq) begin
        mClearing = 1'b1;
        mIdx      = 0;
      end
    end
  endtask

  // One clock: sample outputs at the falling edge, then take the rising edge.
  task automatic stepCycle(input bit doCheck);
    #4;
    if (doCheck) begin
      checkOutput("rs1Data", rs1Data, modelRead(rs1Addr));
      checkOutput("rs2Data", rs2Data, modelRead(rs2Addr));
      checkOutput("rs1Pend", {31'd0, rs1Pend}, {31'd0, modelPend(rs1Addr)});
      checkOutput("rs2Pend", {31'd0, rs2Pend}, {31'd0, modelPend(rs2Addr)});
      checkOutput("busy", {31'd0, busy}, {31'd0, mClearing});
      checkOutput("dbgData", dbgData, modelStored(dbgAddr));
      checkOutput("noBypassRs1", nbRs1Data, modelStored(rs1Addr));
    end
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic [4:0] wa,
                               input logic [31:0] wd, input logic [4:0] a1,
                               input logic [4:0] a2, input logic s, input logic [4:0] sa,
                               input logic c, input logic [4:0] da);
    rst = r; we = w; wtAddr = wa; wtData = wd; rs1Addr = a1; rs2Addr = a2;
    sbSet = s; sbAddr = sa; clrReq = c; dbgAddr = da;
  endtask

  // Counts busy cycles after a clr_req pulse; bounded so a stuck engine fails.
  task automatic countBusy(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      applyStimulus(1, 0, 0, 0, 5'(n), 5'(31 - n), 0, 0, 0, 5'(n));
      stepCycle(1);
      n++;
    end
    checkOutput(name, n, 32);
  endtask

  // After a reset every address must read 0 and nothing may be pending.
  task automatic sweepZero();
    for (int i = 0; i < 32; i++) begin
      applyStimulus(1, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, 0, 5'(i));
      #2;
      checkOutput("rstDbgZero", dbgData, 32'd0);
      checkOutput("rstRs1Zero", rs1Data, 32'd0);
      checkOutput("rstRs2Zero", rs2Data, 32'd0);
      checkOutput("rstPend", {30'd0, rs1Pend, rs2Pend}, 32'd0);
      checkOutput("rstBusy", {31'd0, busy}, 32'd0);
      stepCycle(1);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        set;
    logic [4:0]  sa;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [31:0] enb;
    logic        p1;
    logic        p2;
  } vec_t;

  vec_t vecs [14];

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) begin
      mMem[i] = 32'd0;
      mSb[i]  = 1'b0;
    end
    mClearing = 1'b0;
    mIdx      = 0;

    //         we wa  wd            a1 a2 set sa  e1            e2            enb           p1 p2
    vecs[0]  = '{1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0,        32'h0,        0, 0};
    vecs[1]  = '{1, 0, 32'h00001234, 5, 0, 0, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0};
    vecs[2]  = '{0, 0, 32'h0,        5, 0, 0, 0, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 0};
    vecs[3]  = '{1, 7, 32'h00000011, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0};
    vecs[4]  = '{1, 7, 32'h00000022, 7, 5, 0, 0, 32'h00000022, 32'hDEADBEEF, 32'h00000011, 0, 0};
    vecs[5]  = '{0, 0, 32'h0,        7, 7, 0, 0, 32'h00000022, 32'h00000022, 32'h00000022, 0, 0};
    vecs[6]  = '{0, 0, 32'h0,        9, 0, 1, 9, 32'h0,        32'h0,        32'h0,        0, 0};
    vecs[7]  = '{0, 0, 32'h0,        9, 9, 0, 0, 32'h0,        32'h0,        32'h0,        1, 1};
    vecs[8]  = '{1, 9, 32'h00000099, 9, 0, 0, 0, 32'h00000099, 32'h0,        32'h0,        0, 0};
    vecs[9]  = '{0, 0, 32'h0,        9, 0, 0, 0, 32'h00000099, 32'h0,        32'h00000099, 0, 0};
    vecs[10] = '{1, 9, 32'h000000AA, 9, 0, 1, 9, 32'h000000AA, 32'h0,        32'h00000099, 0, 0};
    vecs[11] = '{0, 0, 32'h0,        9, 0, 0, 0, 32'h000000AA, 32'h0,        32'h000000AA, 1, 0};
    vecs[12] = '{0, 0, 32'h0,        0, 9, 1, 0, 32'h0,        32'h000000AA, 32'h0,        0, 1};
    vecs[13] = '{0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        0, 0};

    // Initial reset: nothing is known before the first edge.
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle(0);
    stepCycle(1);

    // Directed vector table.
    for (int i = 0; i < 14; i++) begin
      applyStimulus(1, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].a1, vecs[i].a2,
                    vecs[i].set, vecs[i].sa, 0, vecs[i].a2);
      #2;
      checkOutput($sformatf("vec%0d.rs1", i), rs1Data, vecs[i].e1);
      checkOutput($sformatf("vec%0d.rs2", i), rs2Data, vecs[i].e2);
      checkOutput($sformatf("vec%0d.nb", i), nbRs1Data, vecs[i].enb);
      checkOutput($sformatf("vec%0d.pend", i), {30'd0, rs1Pend, rs2Pend},
                  {30'd0, vecs[i].p1, vecs[i].p2});
      stepCycle(1);
    end

    // Fill 1..31, then a full clear with a write to 30 dropped mid-clear.
    for (int k = 1; k < 32; k++) begin
      applyStimulus(1, 1, 5'(k), 32'hA500 + k, 0, 0, 0, 0, 0, 0);
      stepCycle(1);
    end
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    stepCycle(1);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      applyStimulus(1, (n == 5), 5'd30, 32'h55, (n == 0) ? 5'd0 : 5'(n - 1),
                    5'd30, (n == 6), 5'd12, (n == 7), 5'(n));
      #2;
      checkOutput("clrEntryZero", rs1Data, 32'd0);
      stepCycle(1);
      n++;
    end
    checkOutput("clrBusyLen", n, 32);
    applyStimulus(1, 0, 0, 0, 5'd30, 5'd12, 0, 0, 0, 5'd30);
    #2;
    checkOutput("clrDroppedWrite", dbgData, 32'd0);
    checkOutput("clrDroppedSet", {31'd0, rs2Pend}, 32'd0);
    stepCycle(1);
    applyStimulus(1, 1, 5'd30, 32'h77, 0, 0, 0, 0, 0, 0);
    stepCycle(1);
    applyStimulus(1, 0, 0, 0, 5'd30, 0, 0, 0, 0, 5'd30);
    #2;
    checkOutput("postClrWrite", rs1Data, 32'h77);
    stepCycle(1);

    // Reset in the middle of a clear, then a fresh full-length clear.
    applyStimulus(1, 1, 5'd3, 32'h333, 0, 0, 1, 5'd20, 0, 0);
    stepCycle(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    stepCycle(1);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 0, 5'd3, 5'd20, 0, 0, 0, 5'd30);
      stepCycle(1);
    end
    applyStimulus(0, 0, 0, 0, 5'd3, 5'd20, 0, 0, 0, 5'd30);
    stepCycle(1);
    sweepZero();
    applyStimulus(1, 1, 5'd1, 32'h1111, 0, 0, 0, 0, 0, 0);
    stepCycle(1);
    applyStimulus(1, 1, 5'd31, 32'h3131, 0, 0, 0, 0, 0, 0);
    stepCycle(1);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    stepCycle(1);
    countBusy("restartBusyLen");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 79) != 0), $urandom_range(0, 1),
                    5'($urandom_range(0, 31)), $urandom,
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 1), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 59) == 0), 5'($urandom_range(0, 31)));
      if ($urandom_range(0, 3) == 0) rs1Addr = wtAddr;
      if ($urandom_range(0, 3) == 0) sbAddr = wtAddr;
      stepCycle(1);
    end

    // Reset after random traffic must leave everything zero.
    applyStimulus(0, 1, 5'd4, 32'hFFFF, 0, 0, 1, 5'd4, 1, 0);
    stepCycle(1);
    sweepZero();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_sb_param.md
Name: regfile_sb_param

Overview:
- Parametrised successor to the 32x32 general-purpose register file for the pipelined core.
- Provides two combinational read ports and one write port, with a write-to-read bypass.
- Adds a per-register pending-write scoreboard for hazard detection in ID, a sequential clear engine (one entry per cycle, busy handshake) and a debug read port.
- Sits between the ID stage (reads, scoreboard set) and the WB stage (writes).

Parameters:
- DATA_W, 32, width of each register in bits.
- ADDR_W, 5, address width. Depth is 2**ADDR_W entries.
- ZERO_REG, 1, when 1, entry 0 always reads 0 and ignores writes and scoreboard sets.
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on the rising edge of clk).
- we  in  1  write enable from WB.
- wt_addr  in  ADDR_W  write address.
- wt_data  in  DATA_W  write data.
- rs1_addr  in  ADDR_W  read port 1 address.
- rs2_addr  in  ADDR_W  read port 2 address.
- rs1_data  out  DATA_W  read port 1 data (combinational).
- rs2_data  out  DATA_W  read port 2 data (combinational).
- rs1_pend  out  1  addressed register has a write outstanding.
- rs2_pend  out  1  addressed register has a write outstanding.
- sb_set  in  1  ID issued an instruction that will write sb_addr.
- sb_addr  in  ADDR_W  destination register being issued.
- clr_req  in  1  request a sequential clear of all entries.
- busy  out  1  clear engine active.
- dbg_addr  in  ADDR_W  debug read address.
- dbg_data  out  DATA_W  debug read data (combinational, no bypass).

Behaviour:
- Reset (rst=0 at an edge):
  - All entries become 0 and all scoreboard bits become 0.
  - FSM goes to IDLE, busy=0, and the clear counter goes to 0.
  - Reset overrides every other input, including an in-progress clear.
- Reads:
  - rsN_data is the stored value of entry rsN_addr.
  - If ZERO_REG=1 and the address is 0, rsN_data=0.
  - If BYPASS=1, FSM is IDLE, we=1, wt_addr==rsN_addr and the address is non-zero (when ZERO_REG), then rsN_data=wt_data in the same cycle.
- Write:
  - When FSM is IDLE and we=1, entry wt_addr <= wt_data at the edge.
  - A write to address 0 is dropped when ZERO_REG=1.
- Scoreboard (one bit per entry):
  - Writes that take effect clear sb[wt_addr].
  - sb_set=1 while IDLE sets sb[sb_addr]. Address 0 is ignored when ZERO_REG=1.
  - Set and clear on the same address in the same cycle: set wins (a newer producer has been issued).
  - rsN_pend = sb[rsN_addr] AND NOT (IDLE & we & wt_addr==rsN_addr).
  - rsN_pend is 0 for address 0 when ZERO_REG=1.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR on clr_req=1. The counter loads 0.
  - In CLEAR, each cycle zeroes entry[cnt] and sb[cnt], then cnt increments.
  - When cnt==2**ADDR_W-1, that entry is zeroed and the FSM returns to IDLE.
  - busy=1 exactly while in CLEAR, i.e. for 2**ADDR_W cycles starting the cycle after clr_req is sampled.
  - While busy: we and sb_set are dropped (not queued), clr_req is ignored and bypass is disabled.
  - Reads return stored contents while busy; entries already cleared read 0.
- Widths: no arithmetic besides the counter. The counter is ADDR_W bits, and termination uses the all-ones compare, not wrap.
- dbg_data is the raw entry at dbg_addr, or 0 for address 0 when ZERO_REG=1.

Test Plan:
- Reset: hold rst=0 one edge after random writes -> every rsN_data=0, dbg_data=0 for all addresses, busy=0, all pend=0.
- Write and read back: we=1, wt_addr=5, wt_data=0xDEADBEEF. Next cycle rs1_addr=5 -> rs1_data=0xDEADBEEF. A write of 0x1234 to address 0 -> rs2_addr=0 still reads 0.
- Bypass: entry 7 holds 0x11. In the same cycle we=1, wt_addr=7, wt_data=0x22, rs1_addr=7 -> rs1_data=0x22 in that cycle. With BYPASS=0 -> 0x11.
- Scoreboard: sb_set to address 9 -> rs1_pend=1 next cycle. A write to 9 -> pend=0 combinationally that cycle and 0 thereafter. sb_set=1 and we=1 both to address 9 in the same cycle -> pend=1 after the edge.
- Clear: fill entries 1..31 with nonzero values, then pulse clr_req -> busy=1 for exactly 32 cycles and entry k reads 0 from cycle k+1 onward. A write issued mid-clear to address 30 (value 0x55) is dropped, so entry 30 reads 0 at the end. After busy falls, writes work again.
- Reset mid-clear: assert rst=0 at cycle 10 of CLEAR -> busy=0 and all entries 0 at the next edge. A clr_req after reset restarts from entry 0 with a full 32-cycle busy window.
